// File: rtl/fetch_pkg.sv
// Types and constants shared by fetch, decode and the pipeline registers.
package fetch_pkg;

    localparam int FETCH_XLEN = 32;
    localparam logic [FETCH_XLEN-1:0] FETCH_NOP = 32'h0000_0013;  // addi x0,x0,0

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// PC, instruction-memory and decode-side signals of the fetch stage.
interface fetch_queue_if #(parameter int XLEN = 32);

    logic [XLEN-1:0] pc_in;
    logic            flush;
    logic            pc_count_enb;
    logic            imem_req;
    logic [XLEN-1:0] imem_rdata;
    logic            dec_valid;
    logic            dec_ready;
    logic [XLEN-1:0] dec_pc;
    logic [XLEN-1:0] dec_instr;

    modport master (
        input  pc_in, flush, imem_rdata, dec_ready,
        output pc_count_enb, imem_req, dec_valid, dec_pc, dec_instr
    );

    modport slave (
        output pc_in, flush, imem_rdata, dec_ready,
        input  pc_count_enb, imem_req, dec_valid, dec_pc, dec_instr
    );

endinterface

// File: rtl/fetch_queue_fifo.sv
// Circular buffer of fetch entries; clear empties it and outranks push/pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int OW    = $clog2(DEPTH + 1)
) (
    input  logic         cpu_clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  fetch_entry_t din,
    output fetch_entry_t dout,
    output logic [OW-1:0] occ
);

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;

    always_ff @(posedge cpu_clk or negedge reset) begin
        if (!reset) begin
            occ    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (clear) begin
            occ    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Storage carries no reset; occ alone says which slots are meaningful.
    always_ff @(posedge cpu_clk) begin
        if (push && !clear) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

    always_ff @(posedge cpu_clk) begin
        if (reset && !clear) begin
            assert (!(push && !pop && occ == OW'(DEPTH)));
            assert (!(pop && occ == '0));
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: issues imem reads only when a queue slot is guaranteed, buffers
// {pc, instr} for decode, and drops all wrong-path work on flush.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              XLEN  = FETCH_XLEN,
    parameter int              DEPTH = 2,
    parameter logic [XLEN-1:0] NOP   = FETCH_NOP
) (
    input logic           cpu_clk,
    input logic           reset,
    fetch_queue_if.master bus
);

    localparam int OW = $clog2(DEPTH + 1);

    logic [OW-1:0]   occ;
    logic            infl_vld;
    logic [XLEN-1:0] infl_pc;
    logic            pop;
    logic            push;
    logic            credit;
    logic [OW:0]     pending;
    fetch_entry_t    wr_entry;
    fetch_entry_t    head;

    always_comb begin
        bus.dec_valid = (occ != '0) && !bus.flush;
        pop           = bus.dec_valid && bus.dec_ready;
        push          = infl_vld && !bus.flush;
        // Slots already promised (queued + in flight) minus the one leaving now.
        pending       = {1'b0, occ} + (OW+1)'(infl_vld) - (OW+1)'(pop);
        credit        = pending < (OW+1)'(DEPTH);
        bus.pc_count_enb = bus.flush || credit;
        bus.imem_req     = credit && !bus.flush && reset;
        wr_entry.pc      = infl_pc;
        wr_entry.instr   = bus.imem_rdata;
        bus.dec_pc       = bus.dec_valid ? head.pc    : '0;
        bus.dec_instr    = bus.dec_valid ? head.instr : NOP;
    end

    always_ff @(posedge cpu_clk or negedge reset) begin
        if (!reset) begin
            infl_vld <= 1'b0;
            infl_pc  <= '0;
        end else begin
            infl_vld <= bus.imem_req;
            if (bus.imem_req) infl_pc <= bus.pc_in;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .cpu_clk (cpu_clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .clear   (bus.flush),
        .din     (wr_entry),
        .dout    (head),
        .occ     (occ)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed and random checks of fetch_queue against hand-computed values and a PC-sequence scoreboard.
module tb_fetch_queue;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] NOPV = 32'h0000_0013;

    logic        cpu_clk = 1'b0;
    logic        reset   = 1'b0;
    logic [31:0] pc_reg;
    logic [31:0] target  = BASE;
    logic [31:0] exp_pc;
    int          errors  = 0;
    int          checks  = 0;
    int          pops    = 0;

    fetch_queue_if #(.XLEN(32)) bus ();

    fetch_queue #(.XLEN(32), .DEPTH(2), .NOP(32'h0000_0013)) dut (
        .cpu_clk (cpu_clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 cpu_clk = ~cpu_clk;

    function automatic logic [31:0] mem_of(input logic [31:0] a);
        return 32'hA0 + ((a - BASE) >> 2);
    endfunction

    // Program counter: loads the redirect target on flush, else +4 when enabled.
    always @(posedge cpu_clk or negedge reset) begin
        if (!reset) pc_reg <= BASE;
        else if (bus.pc_count_enb) pc_reg <= bus.flush ? target : pc_reg + 32'd4;
    end
    assign bus.pc_in = pc_reg;

    // Synchronous instruction memory with one cycle of read latency.
    always @(posedge cpu_clk) begin
        if (bus.imem_req) bus.imem_rdata <= mem_of(bus.pc_in);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge cpu_clk);
        @(negedge cpu_clk);
    endtask

    initial begin
        bus.dec_ready = 1'b1;
        bus.flush     = 1'b0;

        // Reset values while reset is held low
        #12;
        check("rst_valid", 32'(bus.dec_valid), 0);
        check("rst_pc", bus.dec_pc, 0);
        check("rst_instr", bus.dec_instr, NOPV);
        check("rst_req", 32'(bus.imem_req), 0);
        check("rst_enb", 32'(bus.pc_count_enb), 1);

        // 1: streaming with dec_ready=1
        @(negedge cpu_clk);
        reset = 1'b1;
        #1;
        check("t1_req", 32'(bus.imem_req), 1);
        step();
        check("t1_valid_c1", 32'(bus.dec_valid), 0);
        step();
        check("t1_valid_c2", 32'(bus.dec_valid), 1);
        check("t1_pc0", bus.dec_pc, BASE);
        check("t1_instr0", bus.dec_instr, 32'hA0);
        for (int n = 1; n <= 4; n++) begin
            step();
            check("t1_pc", bus.dec_pc, BASE + 32'(4 * n));
            check("t1_instr", bus.dec_instr, 32'hA0 + 32'(n));
            check("t1_enb", 32'(bus.pc_count_enb), 1);
        end

        // 2: fill with dec_ready=0, then drain in order
        reset = 1'b0;
        bus.dec_ready = 1'b0;
        #1;
        check("t2_async_valid", 32'(bus.dec_valid), 0);
        reset = 1'b1;
        step(); step(); step();
        check("t2_occ", 32'(dut.occ), 2);
        check("t2_infl", 32'(dut.infl_vld), 0);
        check("t2_enb", 32'(bus.pc_count_enb), 0);
        check("t2_req", 32'(bus.imem_req), 0);
        bus.dec_ready = 1'b1;
        #1;
        check("t2_pc0", bus.dec_pc, BASE);
        check("t2_enb_pop", 32'(bus.pc_count_enb), 1);
        step();
        check("t2_pc1", bus.dec_pc, BASE + 32'h4);
        step();
        check("t2_pc2", bus.dec_pc, BASE + 32'h8);
        check("t2_instr2", bus.dec_instr, 32'hA2);

        // 3: flush with a full queue
        bus.dec_ready = 1'b0;
        step();
        check("t3_full", 32'(dut.occ), 2);
        bus.flush = 1'b1;
        target = BASE + 32'h100;
        #1;
        check("t3_fl_valid", 32'(bus.dec_valid), 0);
        check("t3_fl_enb", 32'(bus.pc_count_enb), 1);
        check("t3_fl_req", 32'(bus.imem_req), 0);
        check("t3_fl_instr", bus.dec_instr, NOPV);
        step();
        bus.flush = 1'b0;
        #1;
        check("t3_occ0", 32'(dut.occ), 0);
        check("t3_infl0", 32'(dut.infl_vld), 0);
        check("t3_req_after", 32'(bus.imem_req), 1);
        step();
        check("t3_valid_c1", 32'(bus.dec_valid), 0);
        step();
        check("t3_valid_c2", 32'(bus.dec_valid), 1);
        check("t3_pc", bus.dec_pc, BASE + 32'h100);
        check("t3_instr", bus.dec_instr, 32'hE0);

        // 4: flush together with dec_ready=1 and a returning instruction
        bus.dec_ready = 1'b1;
        step();
        check("t4_pre_pc", bus.dec_pc, BASE + 32'h104);
        check("t4_pre_infl", 32'(dut.infl_vld), 1);
        bus.flush = 1'b1;
        target = BASE + 32'h200;
        #1;
        check("t4_fl_valid", 32'(bus.dec_valid), 0);
        step();
        check("t4_occ0", 32'(dut.occ), 0);
        check("t4_infl0", 32'(dut.infl_vld), 0);
        // held flush: queue stays empty, PC keeps loading
        target = BASE + 32'h300;
        for (int k = 0; k < 2; k++) begin
            #1;
            check("t4_hold_enb", 32'(bus.pc_count_enb), 1);
            check("t4_hold_req", 32'(bus.imem_req), 0);
            step();
            check("t4_hold_occ", 32'(dut.occ), 0);
        end
        bus.flush = 1'b0;
        #1;
        check("t4_req", 32'(bus.imem_req), 1);
        step(); step();
        check("t4_pc", bus.dec_pc, BASE + 32'h300);
        check("t4_instr", bus.dec_instr, 32'h160);

        // 5: asynchronous reset with a full queue
        bus.dec_ready = 1'b0;
        step(); step();
        check("t5_full", 32'(dut.occ), 2);
        #2;
        reset = 1'b0;
        #1;
        check("t5_valid", 32'(bus.dec_valid), 0);
        check("t5_instr", bus.dec_instr, NOPV);
        check("t5_pc", bus.dec_pc, 0);
        check("t5_req", 32'(bus.imem_req), 0);
        check("t5_occ", 32'(dut.occ), 0);
        @(negedge cpu_clk);
        reset = 1'b1;

        // 6: random dec_ready/flush against the PC-sequence scoreboard
        exp_pc = BASE;
        for (int i = 0; i < 10000; i++) begin
            bus.dec_ready = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 31) == 0);
            target        = BASE + (32'($urandom_range(0, 1023)) << 2);
            #1;
            if (bus.dec_valid && bus.dec_ready) begin
                check("sb_pc", bus.dec_pc, exp_pc);
                check("sb_instr", bus.dec_instr, mem_of(exp_pc));
                exp_pc = exp_pc + 32'd4;
                pops++;
            end else if (!bus.dec_valid) begin
                check("sb_nop", bus.dec_instr, NOPV);
            end
            if (bus.flush) exp_pc = target;
            check("sb_occ_bound", 32'(dut.occ > 2'd2), 0);
            @(negedge cpu_clk);
        end
        check("sb_progress", 32'(pops > 3000), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
